// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared constants for the max-pool output packer
package pool_pkg;

    localparam int POOL_DATA_WIDTH = 16;
    localparam int MAX_POOL_DIM    = 208;
    localparam int POOL_DIM_WIDTH  = $clog2(MAX_POOL_DIM + 1);
    localparam int PIX_CNT_W       = 16;

    typedef logic [1:0] pool_state_t;

    localparam pool_state_t ST_IDLE  = 2'd0;
    localparam pool_state_t ST_RUN   = 2'd1;
    localparam pool_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with extra-bit full/empty pointers
module sync_fifo
    import pool_pkg::*;
#(
    parameter int WIDTH = 2 * POOL_DATA_WIDTH + 3,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign o_empty    = (wr_ptr == rd_ptr);
    assign o_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push    = i_push && (!o_full || do_pop);
    assign o_pop_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Pointer advance; reset discards all entries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pool_out_packer.sv
// rtl/pool_out_packer.sv - packs pooled pixel pairs into 32-bit stream words; POOL_PACK_STATS_EN adds a stall counter
module pool_out_packer
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = POOL_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int DIM_WIDTH  = POOL_DIM_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [DIM_WIDTH-1:0]    i_out_width,
    input  logic [DIM_WIDTH-1:0]    i_out_height,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_valid,
    output logic [2*DATA_WIDTH-1:0] o_tdata,
    output logic [1:0]              o_tkeep,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    i_tready,
    output logic                    o_busy,
    output logic                    o_done,
`ifdef POOL_PACK_STATS_EN
    output logic [15:0]             o_stall_cnt,
`endif
    output logic                    o_overflow
);

    localparam int FW = 2 * DATA_WIDTH + 3;

    pool_state_t              state;
    logic [PIX_CNT_W-1:0]     total;
    logic [PIX_CNT_W-1:0]     pix_cnt;
    logic                     half;
    logic [DATA_WIDTH-1:0]    pack_lo;
    logic                     last_lost;
    logic [2*DIM_WIDTH-1:0]   dim_prod;

    logic                     beat;
    logic                     last_beat;
    logic                     push;
    logic [FW-1:0]            push_word;
    logic                     pop;
    logic                     drop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FW-1:0]            head;
    logic                     head_last;

    assign dim_prod  = (2*DIM_WIDTH)'(i_out_width) * (2*DIM_WIDTH)'(i_out_height);
    assign beat      = (state == ST_RUN) && i_valid;
    assign last_beat = (pix_cnt == total - PIX_CNT_W'(1));
    assign pop       = !fifo_empty && i_tready;
    // The pool stage cannot be stalled, so a word arriving at a full FIFO is lost.
    assign drop      = push && fifo_full && !pop;
    assign head_last = head[FW-1];

    // Word assembly: pairs go out as {later, earlier}; an odd final pixel goes out alone.
    always_comb begin
        push      = 1'b0;
        push_word = {1'b0, 2'b11, i_data, pack_lo};
        if (beat) begin
            if (half) begin
                push      = 1'b1;
                push_word = {last_beat, 2'b11, i_data, pack_lo};
            end else if (last_beat) begin
                push      = 1'b1;
                push_word = {1'b1, 2'b01, {DATA_WIDTH{1'b0}}, i_data};
            end
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (push_word),
        .o_full      (fifo_full),
        .i_pop       (pop),
        .o_pop_data  (head),
        .o_empty     (fifo_empty)
    );

    assign o_tvalid = !fifo_empty;
    assign o_tdata  = fifo_empty ? '0 : head[2*DATA_WIDTH-1:0];
    assign o_tkeep  = fifo_empty ? 2'b00 : head[FW-2:FW-3];
    assign o_tlast  = !fifo_empty && head_last;

    // Frame control: arm on start, count beats, wait for the last word to leave.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            total      <= '0;
            pix_cnt    <= '0;
            half       <= 1'b0;
            pack_lo    <= '0;
            last_lost  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        total      <= PIX_CNT_W'(dim_prod);
                        pix_cnt    <= '0;
                        half       <= 1'b0;
                        last_lost  <= 1'b0;
                        o_overflow <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_valid) begin
                        pix_cnt <= pix_cnt + PIX_CNT_W'(1);
                        if (!half) begin
                            pack_lo <= i_data;
                        end
                        half <= !half;
                        if (last_beat) begin
                            half      <= 1'b0;
                            last_lost <= drop;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A dropped last word can never be handshaken, so finish at once.
                    if (last_lost || (pop && head_last)) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

`ifdef POOL_PACK_STATS_EN
    // Back-pressure statistics: cycles the consumer refuses a ready word during a frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
        end else if ((state == ST_IDLE) && i_start) begin
            o_stall_cnt <= '0;
        end else if (o_busy && o_tvalid && !i_tready && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_out_packer.sv
// tb/tb_pool_out_packer.sv - directed scoreboard bench for pool_out_packer
module tb_pool_out_packer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int DIMW  = 8;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_start;
    logic [DIMW-1:0] i_out_width;
    logic [DIMW-1:0] i_out_height;
    logic [DW-1:0]   i_data;
    logic            i_valid;
    logic [2*DW-1:0] o_tdata;
    logic [1:0]      o_tkeep;
    logic            o_tlast;
    logic            o_tvalid;
    logic            i_tready;
    logic            o_busy;
    logic            o_done;
    logic            o_overflow;
`ifdef POOL_PACK_STATS_EN
    logic [15:0]     o_stall_cnt;
`endif

    always #5 i_clk = ~i_clk;

    pool_out_packer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .DIM_WIDTH  (DIMW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_out_width  (i_out_width),
        .i_out_height (i_out_height),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_tdata      (o_tdata),
        .o_tkeep      (o_tkeep),
        .o_tlast      (o_tlast),
        .o_tvalid     (o_tvalid),
        .i_tready     (i_tready),
        .o_busy       (o_busy),
        .o_done       (o_done),
`ifdef POOL_PACK_STATS_EN
        .o_stall_cnt  (o_stall_cnt),
`endif
        .o_overflow   (o_overflow)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_hs   = 0;
    int          n_last = 0;
    int          n_done = 0;
    bit          done_chk  = 1'b1;
    bit          done_pend = 1'b0;
    bit          prev_stall = 1'b0;
    logic [34:0] prev_word;
    logic [34:0] cur_word;
    logic [34:0] exp_word;
    logic [34:0] sb[$];

    bit          m_run  = 1'b0;
    int          m_total;
    int          m_cnt;
    bit          m_half;
    logic [15:0] m_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Output monitor: scoreboard compare on handshake, hold rules, done timing.
    always @(negedge i_clk) begin
        cur_word = {o_tlast, o_tkeep, o_tdata};
        if (done_chk && (o_done || done_pend)) check("done_pulse", 64'(o_done), 64'(done_pend));
        if (o_done) n_done++;
        if (prev_stall) begin
            check("hold_valid", 64'(o_tvalid), 64'd1);
            check("hold_word", 64'(cur_word), 64'(prev_word));
        end
        done_pend = 1'b0;
        if (o_tvalid && i_tready && !i_rst) begin
            n_hs++;
            if (o_tlast) n_last++;
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_word = sb.pop_front();
                check("word", 64'(cur_word), 64'(exp_word));
            end
            done_pend = o_tlast;
        end
        prev_stall = o_tvalid && !i_tready && !i_rst;
        prev_word  = cur_word;
    end

    // One clock of stimulus; the model predicts words and drops.
    task automatic step(input bit v, input logic [15:0] d, input bit rdy);
        logic [34:0] w;
        bit          has_w;
        i_valid  = v;
        i_data   = d;
        i_tready = rdy;
        has_w    = 1'b0;
        w        = '0;
        if (v && m_run) begin
            if (m_cnt == m_total - 1) begin
                w     = m_half ? {1'b1, 2'b11, d, m_lo} : {1'b1, 2'b01, 16'h0000, d};
                has_w = 1'b1;
                m_run = 1'b0;
            end else if (m_half) begin
                w     = {1'b0, 2'b11, d, m_lo};
                has_w = 1'b1;
            end else begin
                m_lo = d;
            end
            m_half = !m_half;
            m_cnt++;
        end
        if (has_w && (sb.size() < DEPTH || (sb.size() > 0 && rdy))) sb.push_back(w);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic start_frame(input int w, input int h);
        i_out_width  = DIMW'(w);
        i_out_height = DIMW'(h);
        i_start      = 1'b1;
        m_run        = 1'b1;
        m_total      = w * h;
        m_cnt        = 0;
        m_half       = 1'b0;
        step(1'b0, 16'h0, i_tready);
        check("busy_after_start", 64'(o_busy), 64'd1);
    endtask

    task automatic drain(input bit rnd, input int budget);
        int i;
        for (i = 0; i < budget && (sb.size() != 0 || o_busy); i++)
            step(1'b0, 16'h0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        check("drain_in_budget", 64'(i < budget), 64'd1);
        step(1'b0, 16'h0, 1'b1);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        sb.delete();
        m_run = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        i_rst = 1'b0;
        check("reset_outputs", 64'({o_tvalid, o_tkeep, o_tlast, o_tdata, o_busy, o_done, o_overflow}), 64'd0);
    endtask

    initial begin
        #(3000000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs0, l0, d0;
        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0; i_tready = 1'b0;
        i_out_width = '0; i_out_height = '0;
        do_reset();

        // 4x2 frame, always ready; a stray start mid-frame must be ignored
        hs0 = n_hs; l0 = n_last; d0 = n_done;
        i_tready = 1'b1;
        start_frame(4, 2);
        for (int p = 1; p <= 8; p++) begin
            if (p == 5) begin
                i_start = 1'b1; i_out_width = 8'd1; i_out_height = 8'd1;
            end
            step(1'b1, 16'(p), 1'b1);
        end
        drain(1'b0, 100);
        check("t4x2_words", 64'(n_hs - hs0), 64'd4);
        check("t4x2_last", 64'(n_last - l0), 64'd1);
        check("t4x2_done", 64'(n_done - d0), 64'd1);

        // Overflow: consumer stalled, 40 pixels back-to-back
        hs0 = n_hs; l0 = n_last; d0 = n_done;
        done_chk = 1'b0;
        i_tready = 1'b0;
        start_frame(40, 1);
        for (int p = 0; p < 32; p++) step(1'b1, 16'(p + 100), 1'b0);
        check("ovf_before_17th", 64'(o_overflow), 64'd0);
        for (int p = 32; p < 34; p++) step(1'b1, 16'(p + 100), 1'b0);
        check("ovf_at_17th", 64'(o_overflow), 64'd1);
        for (int p = 34; p < 40; p++) step(1'b1, 16'(p + 100), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
        check("ovf_busy_clear", 64'(o_busy), 64'd0);
        check("ovf_done", 64'(n_done - d0), 64'd1);
        check("ovf_held_valid", 64'(o_tvalid), 64'd1);
        drain(1'b0, 100);
        check("ovf_drained", 64'(n_hs - hs0), 64'd16);
        check("ovf_no_tlast", 64'(n_last - l0), 64'd0);
        check("ovf_sticky", 64'(o_overflow), 64'd1);
        check("ovf_empty", 64'(o_tvalid), 64'd0);
        done_chk = 1'b1;

        // 3x1 odd frame
        hs0 = n_hs; l0 = n_last; d0 = n_done;
        i_tready = 1'b1;
        start_frame(3, 1);
        check("ovf_cleared_on_start", 64'(o_overflow), 64'd0);
        step(1'b1, 16'h0010, 1'b1);
        step(1'b1, 16'h0020, 1'b1);
        step(1'b1, 16'h0030, 1'b1);
        drain(1'b0, 100);
        check("t3x1_words", 64'(n_hs - hs0), 64'd2);
        check("t3x1_last", 64'(n_last - l0), 64'd1);
        check("t3x1_done", 64'(n_done - d0), 64'd1);

        // Reset mid-frame with words held, then a clean 2x2 frame
        i_tready = 1'b0;
        start_frame(4, 4);
        for (int p = 1; p <= 5; p++) step(1'b1, 16'(p + 16'h0F00), 1'b0);
        check("pre_reset_valid", 64'(o_tvalid), 64'd1);
        do_reset();
        hs0 = n_hs; l0 = n_last;
        i_tready = 1'b1;
        start_frame(2, 2);
        for (int p = 0; p < 4; p++) step(1'b1, 16'(16'h00A1 + p), 1'b1);
        drain(1'b0, 100);
        check("rst_words", 64'(n_hs - hs0), 64'd2);
        check("rst_last", 64'(n_last - l0), 64'd1);

        // Maximum frame, pixels on 2 of 3 cycles, random back-pressure
        hs0 = n_hs; l0 = n_last; d0 = n_done;
        start_frame(208, 208);
        for (int p = 0; p < 43264; p++) begin
            step(1'b1, 16'(p * 3 + 7), 1'($urandom_range(0, 1)));
            if (p % 2 == 1) step(1'b0, 16'h0, 1'($urandom_range(0, 1)));
        end
        drain(1'b1, 2000);
        check("big_words", 64'(n_hs - hs0), 64'd21632);
        check("big_last", 64'(n_last - l0), 64'd1);
        check("big_done", 64'(n_done - d0), 64'd1);
        check("big_no_overflow", 64'(o_overflow), 64'd0);

`ifdef POOL_PACK_STATS_EN
        // Stall counter: consumer refuses a visible word for 7 cycles
        i_tready = 1'b0;
        start_frame(2, 2);
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h0003, 1'b0);
        step(1'b1, 16'h0004, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0);
        drain(1'b0, 100);
        check("stall_cnt", 64'(o_stall_cnt), 64'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
